// File: rtl/branch_resolve_ctrl_pkg.sv
// p5_defs: shared opcode, forwarding-source and branch FSM encodings for the P5 ID stage.
package p5_defs;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB = 2'd2;
  typedef enum logic [1:0] {IDLE, STALL, RESOLVE} state_t;
endpackage

// File: rtl/branch_resolve_ctrl_hazard.sv
// branch_hazard_calc: stall need and forwarding source for one comparator operand.
module branch_hazard_calc
  import p5_defs::*;
(
  input  logic [4:0] src,
  input  logic [4:0] ex_wa,
  input  logic       ex_we,
  input  logic       ex_ld,
  input  logic [4:0] mem_wa,
  input  logic       mem_we,
  input  logic       mem_ld,
  input  logic [4:0] wb_wa,
  input  logic       wb_we,
  output logic [1:0] need,
  output logic [1:0] fwd
);
  logic nz;
  assign nz = |src;
  always_comb begin
    need = !nz ? 2'd0 :
           (src == ex_wa && ex_we) ? (ex_ld ? 2'd2 : 2'd1) :
           (src == mem_wa && mem_we && mem_ld) ? 2'd1 : 2'd0;
    fwd = !nz ? FWD_RF :
          (src == mem_wa && mem_we && !mem_ld) ? FWD_MEM :
          (src == wb_wa && wb_we) ? FWD_WB : FWD_RF;
  end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: ID-stage beq/bne scheduler - stalls for operands, picks forwards, drives PC select.
module branch_resolve_ctrl
  import p5_defs::*;
#(
  parameter int CNT_W = 16,
  parameter bit DELAY_SLOT = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic             id_kill,
  input  logic [5:0]       id_op,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_wa,
  input  logic             ex_we,
  input  logic             ex_ld,
  input  logic [4:0]       mem_wa,
  input  logic             mem_we,
  input  logic             mem_ld,
  input  logic [4:0]       wb_wa,
  input  logic             wb_we,
  input  logic             cmp_eq,
  output logic [1:0]       fwd_rs_sel,
  output logic [1:0]       fwd_rt_sel,
  output logic             stall,
  output logic             pc_src,
  output logic             flush_ifid,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);
  state_t state;
  logic [1:0] scnt, need_rs, need_rt, need, fs, ft;
  logic is_br, resolve, taken;

  branch_hazard_calc u_rs (
    .src(id_rs), .ex_wa(ex_wa), .ex_we(ex_we), .ex_ld(ex_ld),
    .mem_wa(mem_wa), .mem_we(mem_we), .mem_ld(mem_ld),
    .wb_wa(wb_wa), .wb_we(wb_we), .need(need_rs), .fwd(fs)
  );
  branch_hazard_calc u_rt (
    .src(id_rt), .ex_wa(ex_wa), .ex_we(ex_we), .ex_ld(ex_ld),
    .mem_wa(mem_wa), .mem_we(mem_we), .mem_ld(mem_ld),
    .wb_wa(wb_wa), .wb_we(wb_we), .need(need_rt), .fwd(ft)
  );

  // RESOLVE trusts the operands it waited for; no hazard re-check there
  always_comb begin
    is_br = id_valid && (id_op == OP_BEQ || id_op == OP_BNE);
    need = (need_rs > need_rt) ? need_rs : need_rt;
    resolve = !id_kill && ((state == IDLE && is_br && need == 2'd0) || state == RESOLVE);
    taken = (id_op == OP_BEQ) ? cmp_eq : !cmp_eq;
    stall = reset_n && !id_kill && ((state == IDLE && is_br && need != 2'd0) || state == STALL);
    pc_src = reset_n && resolve && taken;
    flush_ifid = DELAY_SLOT ? 1'b0 : pc_src;
    fwd_rs_sel = reset_n ? fs : FWD_RF;
    fwd_rt_sel = reset_n ? ft : FWD_RF;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      scnt <= 2'd0;
      br_cnt <= '0;
      taken_cnt <= '0;
    end else if (id_kill) begin
      state <= IDLE;
      scnt <= 2'd0;
    end else begin
      if (resolve) begin
        br_cnt <= br_cnt + CNT_W'(1);
        taken_cnt <= taken_cnt + CNT_W'(taken);
      end
      case (state)
        IDLE: if (is_br && need != 2'd0) begin
          scnt <= need - 2'd1;
          state <= (need == 2'd2) ? STALL : RESOLVE;
        end
        STALL: begin
          scnt <= scnt - 2'd1;
          state <= (scnt <= 2'd1) ? RESOLVE : STALL;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed vectors, literal checks plus a latency-based reference model
// checked every cycle on two instances (16-bit counters with delay slot, 2-bit counters without).
module tb_branch_resolve_ctrl;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;

  logic clk, reset_n, id_valid, id_kill, ex_we, ex_ld, mem_we, mem_ld, wb_we, cmp_eq;
  logic [5:0] id_op;
  logic [4:0] id_rs, id_rt, ex_wa, mem_wa, wb_wa;
  logic [1:0] frs_a, frt_a, frs_b, frt_b;
  logic stall_a, pc_a, fl_a, stall_b, pc_b, fl_b;
  logic [15:0] br_a, tk_a;
  logic [1:0] br_b, tk_b;

  int checks = 0;
  int errors = 0;
  int wl = -1;
  int m_br = 0;
  int m_tk = 0;

  branch_resolve_ctrl #(.CNT_W(16), .DELAY_SLOT(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_kill(id_kill), .id_op(id_op),
    .id_rs(id_rs), .id_rt(id_rt), .ex_wa(ex_wa), .ex_we(ex_we), .ex_ld(ex_ld),
    .mem_wa(mem_wa), .mem_we(mem_we), .mem_ld(mem_ld), .wb_wa(wb_wa), .wb_we(wb_we),
    .cmp_eq(cmp_eq), .fwd_rs_sel(frs_a), .fwd_rt_sel(frt_a), .stall(stall_a),
    .pc_src(pc_a), .flush_ifid(fl_a), .br_cnt(br_a), .taken_cnt(tk_a)
  );
  branch_resolve_ctrl #(.CNT_W(2), .DELAY_SLOT(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_kill(id_kill), .id_op(id_op),
    .id_rs(id_rs), .id_rt(id_rt), .ex_wa(ex_wa), .ex_we(ex_we), .ex_ld(ex_ld),
    .mem_wa(mem_wa), .mem_we(mem_we), .mem_ld(mem_ld), .wb_wa(wb_wa), .wb_we(wb_we),
    .cmp_eq(cmp_eq), .fwd_rs_sel(frs_b), .fwd_rt_sel(frt_b), .stall(stall_b),
    .pc_src(pc_b), .flush_ifid(fl_b), .br_cnt(br_b), .taken_cnt(tk_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, act, exp);
    end
  endtask

  // cycles a producer keeps the operand unavailable to the ID comparator
  function automatic int lat(input logic [4:0] s);
    if (s == 5'd0) return 0;
    if (ex_we && s == ex_wa) return ex_ld ? 2 : 1;
    if (mem_we && mem_ld && s == mem_wa) return 1;
    return 0;
  endfunction

  function automatic int src(input logic [4:0] s);
    if (s == 5'd0) return 0;
    if (mem_we && !mem_ld && s == mem_wa) return 1;
    if (wb_we && s == wb_wa) return 2;
    return 0;
  endfunction

  always @(negedge clk) begin
    int l, es, er, tk, ep;
    if (!reset_n) begin
      wl = -1; m_br = 0; m_tk = 0;
      chk("rst_stall_a", stall_a, 0); chk("rst_pc_a", pc_a, 0); chk("rst_fwd_a", {frs_a, frt_a}, 0);
      chk("rst_cnt_a", {br_a, tk_a}, 0); chk("rst_stall_b", stall_b, 0); chk("rst_pc_b", pc_b, 0);
      chk("rst_fl_b", fl_b, 0); chk("rst_fwd_b", {frs_b, frt_b}, 0); chk("rst_cnt_b", {br_b, tk_b}, 0);
    end else begin
      l = (lat(id_rs) > lat(id_rt)) ? lat(id_rs) : lat(id_rt);
      es = 0; er = 0;
      if (!id_kill) begin
        if (wl < 0) begin
          if (id_valid && (id_op == BEQ || id_op == BNE)) begin
            if (l == 0) er = 1; else es = 1;
          end
        end else if (wl > 0) es = 1;
        else er = 1;
      end
      tk = (id_op == BEQ) ? int'(cmp_eq) : int'(!cmp_eq);
      ep = er & tk;
      chk("stall_a", stall_a, es); chk("stall_b", stall_b, es);
      chk("pc_a", pc_a, ep); chk("pc_b", pc_b, ep);
      chk("flush_a", fl_a, 0); chk("flush_b", fl_b, ep);
      chk("fwd_rs_a", frs_a, src(id_rs)); chk("fwd_rt_a", frt_a, src(id_rt));
      chk("fwd_rs_b", frs_b, src(id_rs)); chk("fwd_rt_b", frt_b, src(id_rt));
      chk("br_a", br_a, m_br & 16'hffff); chk("tk_a", tk_a, m_tk & 16'hffff);
      chk("br_b", br_b, m_br & 3); chk("tk_b", tk_b, m_tk & 3);
      if (id_kill) wl = -1;
      else if (wl < 0) wl = es ? l - 1 : -1;
      else wl = wl - 1;
      if (er) begin m_br++; m_tk += tk; end
    end
  end

  task automatic clr();
    id_valid = 0; id_kill = 0; id_op = 0; id_rs = 0; id_rt = 0; cmp_eq = 0;
    ex_wa = 0; ex_we = 0; ex_ld = 0; mem_wa = 0; mem_we = 0; mem_ld = 0; wb_wa = 0; wb_we = 0;
  endtask

  task automatic br(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic eq);
    id_valid = 1; id_op = op; id_rs = rs; id_rt = rt; cmp_eq = eq;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 0; clr();
    nxt(); #3;
    chk("lit_rst_br", br_a, 0); chk("lit_rst_stall", stall_a, 0);
    nxt(); reset_n = 1;
    // 1: no hazard, taken beq resolves in ID
    br(BEQ, 1, 2, 1); #3;
    chk("t1_pc", pc_a, 1); chk("t1_stall", stall_a, 0);
    nxt(); clr(); #3;
    chk("t1_br", br_a, 1); chk("t1_tk", tk_a, 1);
    // 2: ALU producer in EX, moves to MEM while stalled
    nxt(); br(BNE, 3, 0, 1); ex_wa = 3; ex_we = 1; #3;
    chk("t2_stall", stall_a, 1); chk("t2_pc0", pc_a, 0);
    nxt(); ex_we = 0; mem_wa = 3; mem_we = 1; #3;
    chk("t2_res_stall", stall_a, 0); chk("t2_fwd_rs", frs_a, 1); chk("t2_pc", pc_a, 0);
    nxt(); clr(); #3;
    chk("t2_br", br_a, 2); chk("t2_tk", tk_a, 1);
    // 3: load in EX, two stalls, resolves from WB
    nxt(); br(BEQ, 5, 4, 0); ex_wa = 4; ex_we = 1; ex_ld = 1; #3;
    chk("t3_stall0", stall_a, 1);
    nxt(); ex_we = 0; ex_ld = 0; mem_wa = 4; mem_we = 1; mem_ld = 1; #3;
    chk("t3_stall1", stall_a, 1);
    nxt(); mem_we = 0; mem_ld = 0; wb_wa = 4; wb_we = 1; cmp_eq = 1; #3;
    chk("t3_stall2", stall_a, 0); chk("t3_fwd_rt", frt_a, 2); chk("t3_pc", pc_a, 1);
    nxt(); clr(); #3;
    chk("t3_br", br_a, 3); chk("t3_tk", tk_a, 2);
    // 4: rs needs 1 (load in MEM), rt needs 2 (load in EX)
    nxt(); br(BNE, 6, 7, 0); mem_wa = 6; mem_we = 1; mem_ld = 1; ex_wa = 7; ex_we = 1; ex_ld = 1; #3;
    chk("t4_stall0", stall_a, 1);
    nxt(); #3 chk("t4_stall1", stall_a, 1);
    nxt(); #3 chk("t4_pc", pc_a, 1); chk("t4_stall2", stall_a, 0);
    nxt(); clr(); br(BEQ, 0, 0, 1);
    ex_we = 1; ex_ld = 1; mem_we = 1; wb_we = 1; #3;
    chk("t4_r0_stall", stall_a, 0); chk("t4_r0_fwd", frs_a, 0); chk("t4_r0_pc", pc_a, 1);
    nxt(); clr(); #3;
    chk("t4_br", br_a, 5); chk("t4_tk", tk_a, 4);
    // 5: kill during STALL, kill over a resolve, async reset mid-STALL
    nxt(); br(BEQ, 5, 4, 1); ex_wa = 4; ex_we = 1; ex_ld = 1; #3;
    chk("t5_stall", stall_a, 1);
    nxt(); id_kill = 1; #3;
    chk("t5_kill_stall", stall_a, 0); chk("t5_kill_pc", pc_a, 0);
    nxt(); clr(); #3;
    chk("t5_idle_stall", stall_a, 0); chk("t5_br", br_a, 5);
    nxt(); br(BEQ, 3, 9, 1); ex_wa = 3; ex_we = 1; #3;
    chk("t5b_stall", stall_a, 1);
    nxt(); id_kill = 1; #3;
    chk("t5b_pc", pc_a, 0);
    nxt(); clr(); #3;
    chk("t5b_br", br_a, 5);
    nxt(); br(BEQ, 5, 4, 1); ex_wa = 4; ex_we = 1; ex_ld = 1; #3;
    chk("t5c_stall", stall_a, 1);
    nxt(); wb_wa = 4; wb_we = 1; #1 reset_n = 0; #1;
    chk("t5c_stall0", stall_a, 0); chk("t5c_fwd0", frt_a, 0); chk("t5c_br0", br_a, 0);
    nxt(); reset_n = 1; clr();
    // 6: 2-bit counters wrap, no delay slot so flush follows pc_src
    for (int i = 0; i < 5; i++) begin
      br(BEQ, 1, 2, 1); #3;
      chk("t6_flush", fl_b, 1);
      nxt();
    end
    clr(); #3;
    chk("t6_br_b", br_b, 1); chk("t6_tk_b", tk_b, 1); chk("t6_br_a", br_a, 5);
    nxt(); br(BNE, 1, 2, 1); #3;
    chk("t6_nt_flush", fl_b, 0);
    nxt(); clr();
    nxt(); nxt();
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
